// File: rtl/regbank_scoreboard.sv
// -----------------------------------------------------------------------------
// regbank_scoreboard
//
// Issue-side scoreboard for the 32-entry register bank in the ID stage. It
// counts register writes that have been issued but have not yet been
// committed by write-back, and uses those counts to hold off issue on:
//   - a read-after-write hazard on a source register,
//   - saturation of the destination register's pending-write counter,
//   - the global in-flight limit DEPTH being reached.
// A flush pulse moves the block into DRAIN. It stays there until every
// pending write has retired, and then it lets issue resume.
//
// Optional feature (compile-time macro):
//   SCOREBOARD_WB_BYPASS_EN
//     When defined, a source register whose last pending write is being
//     written back in the same cycle is not treated as a hazard. This relies
//     on the register bank's write-before-read behaviour. When the macro is
//     not defined, the reader waits one extra cycle.
//
// Parameters:
//   DEPTH  - global limit on pending writes (1..15)
//   CNT_W  - width of each per-register counter; saturates at 2^CNT_W-1
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous reset, active-high
//   issue_valid  in   ID presents an instruction
//   issue_rs1    in   [4:0] first source register
//   issue_rs2    in   [4:0] second source register
//   issue_rd     in   [4:0] destination register
//   issue_wr     in   instruction writes issue_rd
//   issue_ready  out  combinational; accept = issue_valid && issue_ready
//   wb_valid     in   write-back commits one register write
//   wb_rd        in   [4:0] register being written back
//   flush        in   one-cycle pulse that starts a drain
//   busy_mask    out  [31:0] bit r set while register r has a pending write
//   inflight     out  [3:0] number of pending writes
//   draining     out  high while in DRAIN
//   err          out  sticky; a write-back arrived with no pending write
// -----------------------------------------------------------------------------
module regbank_scoreboard #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic [4:0]  issue_rd,
  input  logic        issue_wr,
  output logic        issue_ready,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        flush,
  output logic [31:0] busy_mask,
  output logic [3:0]  inflight,
  output logic        draining,
  output logic        err
);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [3:0]       DEPTH_L = 4'(DEPTH);

  state_t                    state_q, state_d;
  logic [31:0][CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]                inflight_q, inflight_d;
  logic                      err_q, err_d;

  logic issue_trk_wr;
  logic issue_inc;
  logic wb_trk;
  logic wb_dec;
  logic wb_spurious;
  logic rs1_pend, rs2_pend;
  logic rs1_bypass, rs2_bypass;
  logic raw_hazard;
  logic room_ok;

  // Classification of this cycle's issue and write-back. A destination of
  // register 0 is never tracked.
  assign issue_trk_wr = issue_wr && (issue_rd != 5'd0);
  assign issue_inc    = issue_valid && issue_ready && issue_trk_wr;
  assign wb_trk       = wb_valid && (wb_rd != 5'd0);
  assign wb_dec       = wb_trk && (cnt_q[wb_rd] != '0);
  assign wb_spurious  = wb_trk && (cnt_q[wb_rd] == '0);

  // A source is pending when it is not register 0 and its counter is
  // non-zero. The counter is the value registered before the edge.
  assign rs1_pend = (issue_rs1 != 5'd0) && (cnt_q[issue_rs1] != '0);
  assign rs2_pend = (issue_rs2 != 5'd0) && (cnt_q[issue_rs2] != '0);

`ifdef SCOREBOARD_WB_BYPASS_EN
  // The last outstanding write to the source lands in the bank this cycle.
  // Because the bank writes before it reads, the reader sees the new value.
  assign rs1_bypass = wb_valid && (wb_rd == issue_rs1) && (cnt_q[issue_rs1] == CNT_ONE);
  assign rs2_bypass = wb_valid && (wb_rd == issue_rs2) && (cnt_q[issue_rs2] == CNT_ONE);
`else
  assign rs1_bypass = 1'b0;
  assign rs2_bypass = 1'b0;
`endif

  assign raw_hazard = (rs1_pend && !rs1_bypass) || (rs2_pend && !rs2_bypass);

  // Capacity is needed only when the instruction adds a tracked write.
  assign room_ok = !issue_trk_wr ||
                   ((cnt_q[issue_rd] != CNT_MAX) && (inflight_q < DEPTH_L));

  // A flush in RUN blocks the issue in that same cycle.
  assign issue_ready = (state_q == RUN) && !rst && !flush && !raw_hazard && room_ok;

  // Per-register counters. If an issue and a write-back hit the same register
  // in one cycle, they cancel. Register 0 is tied to zero.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_cnt
      if (gi == 0) begin : g_zero
        assign cnt_d[gi] = '0;
      end else begin : g_track
        logic inc;
        logic dec;
        assign inc       = issue_inc && (issue_rd == 5'(gi));
        assign dec       = wb_dec && (wb_rd == 5'(gi));
        assign cnt_d[gi] = cnt_q[gi] + CNT_W'(inc) - CNT_W'(dec);
      end
      assign busy_mask[gi] = |cnt_q[gi];
    end
  endgenerate

  assign inflight_d = inflight_q + 4'(issue_inc) - 4'(wb_dec);
  assign err_d      = err_q | wb_spurious;

  // DRAIN exits only after a quiet cycle: nothing is pending, and no tracked
  // write-back or new flush arrives in that cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (flush) state_d = DRAIN;
      DRAIN:   if (!flush && (inflight_q == 4'd0) && !wb_trk) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      inflight_q <= 4'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign inflight = inflight_q;
  assign draining = (state_q == DRAIN);
  assign err      = err_q;

endmodule

// File: tb/tb_regbank_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_regbank_scoreboard
//
// Self-checking bench for regbank_scoreboard with the default parameters
// (DEPTH=4, CNT_W=2). A table of vectors is applied one per cycle. Inputs are
// driven at the falling edge, and issue_ready is checked shortly afterwards.
// The expected registered state is pushed to a queue, then popped and
// compared just after the next rising edge. A hand-written sequence covers
// asynchronous reset in the middle of a drain.
// -----------------------------------------------------------------------------
module tb_regbank_scoreboard;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_wr;
  logic        issue_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [31:0] busy_mask;
  logic [3:0]  inflight;
  logic        draining;
  logic        err;

  regbank_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_rd    (issue_rd),
    .issue_wr    (issue_wr),
    .issue_ready (issue_ready),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .flush       (flush),
    .busy_mask   (busy_mask),
    .inflight    (inflight),
    .draining    (draining),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wr;
    logic        wbv;
    logic [4:0]  wbrd;
    logic        fl;
    logic        exp_rdy;
    logic [31:0] exp_busy;
    logic [3:0]  exp_inf;
    logic        exp_drn;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic [31:0] busy;
    logic [3:0]  inf;
    logic        drn;
    logic        er;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input logic iv, input int rs1, input int rs2, input int rd,
                              input logic wr, input logic wbv, input int wbrd, input logic fl,
                              input logic rdy, input logic [31:0] busy, input int inf,
                              input logic drn, input logic er);
    vec_t v;
    v.iv = iv; v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd); v.wr = wr;
    v.wbv = wbv; v.wbrd = 5'(wbrd); v.fl = fl;
    v.exp_rdy = rdy; v.exp_busy = busy; v.exp_inf = 4'(inf);
    v.exp_drn = drn; v.exp_err = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_rd = 5'd0;
    issue_wr = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0; flush = 1'b0;
  endtask

  // Watchdog so the run always ends, even if something stalls the bench.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    // Columns: iv rs1 rs2 rd wr | wbv wbrd | fl || ready busy inflight drain err
    // RAW hazard on register 5
    vecs.push_back(mk(1, 0, 0, 5, 1, 0, 0, 0, 1, 32'h20,  1, 0, 0));
    vecs.push_back(mk(1, 5, 0, 6, 1, 0, 0, 0, 0, 32'h20,  1, 0, 0));
`ifdef SCOREBOARD_WB_BYPASS_EN
    vecs.push_back(mk(1, 5, 0, 6, 1, 1, 5, 0, 1, 32'h40,  1, 0, 0));
    vecs.push_back(mk(0, 5, 0, 6, 1, 0, 0, 0, 1, 32'h40,  1, 0, 0));
`else
    vecs.push_back(mk(1, 5, 0, 6, 1, 1, 5, 0, 0, 32'h0,   0, 0, 0));
    vecs.push_back(mk(1, 5, 0, 6, 1, 0, 0, 0, 1, 32'h40,  1, 0, 0));
`endif
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 6, 0, 1, 32'h0,   0, 0, 0));
    // Global DEPTH limit
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 1, 32'h2,   1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 2, 1, 0, 0, 0, 1, 32'h6,   2, 0, 0));
    vecs.push_back(mk(1, 0, 0, 3, 1, 0, 0, 0, 1, 32'hE,   3, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4, 1, 0, 0, 0, 1, 32'h1E,  4, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8, 1, 0, 0, 0, 0, 32'h1E,  4, 0, 0));
    vecs.push_back(mk(1, 9, 10, 8, 0, 0, 0, 0, 1, 32'h1E, 4, 0, 0));
    vecs.push_back(mk(1, 3, 0, 8, 0, 0, 0, 0, 0, 32'h1E,  4, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h1C,  3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2, 0, 1, 32'h18,  2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 3, 0, 1, 32'h10,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 4, 0, 1, 32'h0,   0, 0, 0));
    // Per-register counter saturation (max 3)
    vecs.push_back(mk(1, 0, 0, 9, 1, 0, 0, 0, 1, 32'h200, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 9, 1, 0, 0, 0, 1, 32'h200, 2, 0, 0));
    vecs.push_back(mk(1, 0, 0, 9, 1, 0, 0, 0, 1, 32'h200, 3, 0, 0));
    vecs.push_back(mk(1, 0, 0, 9, 1, 0, 0, 0, 0, 32'h200, 3, 0, 0));
    vecs.push_back(mk(1, 0, 0, 9, 1, 1, 9, 0, 0, 32'h200, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 9, 0, 1, 32'h200, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 9, 0, 1, 32'h0,   0, 0, 0));
    // Same-register issue and write-back in one cycle
    vecs.push_back(mk(1, 0, 0, 7, 1, 0, 0, 0, 1, 32'h80,  1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 7, 1, 1, 7, 0, 1, 32'h80,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 7, 0, 1, 32'h0,   0, 0, 0));
    // Register 0 is never tracked
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 1, 32'h0,   0, 0, 0));
    // Flush and drain
    vecs.push_back(mk(1, 0, 0, 11, 1, 0, 0, 0, 1, 32'h800, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 12, 1, 0, 0, 0, 1, 32'h1800, 2, 0, 0));
    vecs.push_back(mk(1, 0, 0, 13, 1, 0, 0, 1, 0, 32'h1800, 2, 1, 0));
    vecs.push_back(mk(1, 0, 0, 13, 1, 0, 0, 1, 0, 32'h1800, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 11, 0, 0, 32'h1000, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 12, 0, 0, 32'h0,   0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0,   0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 12, 0, 1, 32'h0,   0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0,   0, 0, 1));

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", 32'(issue_ready), 32'd0);
    chk("rst.busy", busy_mask, 32'h0);
    chk("rst.inflight", 32'(inflight), 32'd0);
    chk("rst.draining", 32'(draining), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_release.ready", 32'(issue_ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      issue_valid = vecs[i].iv;  issue_rs1 = vecs[i].rs1; issue_rs2 = vecs[i].rs2;
      issue_rd = vecs[i].rd;     issue_wr = vecs[i].wr;
      wb_valid = vecs[i].wbv;    wb_rd = vecs[i].wbrd;    flush = vecs[i].fl;
      #1;
      chk($sformatf("v%0d.ready", i), 32'(issue_ready), 32'(vecs[i].exp_rdy));
      sb_q.push_back('{busy: vecs[i].exp_busy, inf: vecs[i].exp_inf,
                       drn: vecs[i].exp_drn, er: vecs[i].exp_err});
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk($sformatf("v%0d.busy", i), busy_mask, e.busy);
      chk($sformatf("v%0d.inflight", i), 32'(inflight), 32'(e.inf));
      chk($sformatf("v%0d.draining", i), 32'(draining), 32'(e.drn));
      chk($sformatf("v%0d.err", i), 32'(err), 32'(e.er));
      $display("vec %0d: rd=%0d wr=%0b wb=%0b/%0d flush=%0b ready=%0b busy=%h inflight=%0d drain=%0b err=%0b",
               i, vecs[i].rd, vecs[i].wr, vecs[i].wbv, vecs[i].wbrd, vecs[i].fl,
               vecs[i].exp_rdy, busy_mask, inflight, draining, err);
    end

    // Asynchronous reset in the middle of a drain
    @(negedge clk);
    idle_inputs(); issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd20;
    @(negedge clk);
    issue_rd = 5'd21;
    @(negedge clk);
    issue_rd = 5'd22;
    @(negedge clk);
    idle_inputs(); flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("drain.busy", busy_mask, 32'h700000);
    chk("drain.inflight", 32'(inflight), 32'd3);
    chk("drain.draining", 32'(draining), 32'd1);
    $display("seq drain: busy=%h inflight=%0d drain=%0b", busy_mask, inflight, draining);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.busy", busy_mask, 32'h0);
    chk("async_rst.inflight", 32'(inflight), 32'd0);
    chk("async_rst.draining", 32'(draining), 32'd0);
    chk("async_rst.err", 32'(err), 32'd0);
    chk("async_rst.ready", 32'(issue_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("async_rst_hold.ready", 32'(issue_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async_rst_release.ready", 32'(issue_ready), 32'd1);
    $display("seq async reset: busy=%h inflight=%0d ready=%0b", busy_mask, inflight, issue_ready);
    @(negedge clk);
    issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd20;
    @(posedge clk);
    #1;
    chk("post_rst.busy", busy_mask, 32'h100000);
    chk("post_rst.inflight", 32'(inflight), 32'd1);
    $display("seq post reset issue: busy=%h inflight=%0d", busy_mask, inflight);
    @(negedge clk);
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regbank_scoreboard.md
# regbank_scoreboard

- Issue-side controller for the 32-entry register bank in the ID stage.
- Tracks which architectural registers have writes still in flight between ID and write-back.
- Holds ID off (`issue_ready` low) on read-after-write hazards, counter saturation or a full pipeline.
- Retires entries as write-back commits; on a flush it drains the pipeline before issue resumes.

## Interface
- `DEPTH`, default 4: maximum instructions with a pending write in flight (global limit, at most 15).
- `CNT_W`, default 2: width of each per-register pending-write counter; it saturates at 2^CNT_W-1.
- `clk` input 1: clock, rising edge. One clock domain.
- `rst` input 1: asynchronous reset, active-high.
- `issue_valid` input 1: ID presents an instruction.
- `issue_rs1` input 5: first source register.
- `issue_rs2` input 5: second source register.
- `issue_rd` input 5: destination register.
- `issue_wr` input 1: instruction writes `issue_rd` (the register bank write enable).
- `issue_ready` output 1: combinational; the instruction is accepted when `issue_valid && issue_ready`.
- `wb_valid` input 1: write-back commits one register write this cycle.
- `wb_rd` input 5: register being written back.
- `flush` input 1: one-cycle pulse that starts a drain.
- `busy_mask` output 32: registered; bit r=1 when register r has a pending write.
- `inflight` output 4: registered count of pending writes.
- `draining` output 1: registered; high in state DRAIN.
- `err` output 1: registered, sticky; a write-back arrived for a register with no pending write.

## Operation
- Register 0 is constant: never marked busy and never counted. Issue or write-back with rd=0 has no effect.
- "Tracked issue" = accepted issue with `issue_wr`=1 and rd≠0.
- "Tracked write-back" = `wb_valid` with `wb_rd`≠0.
- Counter `cnt[r]`:
  - +1 on a tracked issue to r.
  - −1 on a tracked write-back to r.
  - Issue and write-back to the same r in the same cycle: unchanged.
- `inflight` follows the same rules globally. `busy_mask[r] = (cnt[r]≠0)`.
- `issue_ready` = state RUN, and `rst` low, and no RAW hazard, and:
  - if `issue_wr`=1 and rd≠0: `cnt[rd]` below saturation and `inflight`<`DEPTH`.
- RAW hazard: rs1 or rs2 is ≠0 and has a pending write, checked against `cnt` as registered before the edge.
- Write-back to a register whose cnt=0:
  - Counters unchanged, `err` set to 1.
  - `err` is cleared only by `rst`.
- State machine:
  - RUN: `flush`=1 → DRAIN (the issue in that cycle is not accepted; `issue_ready` is forced 0).
  - DRAIN: `issue_ready`=0; write-backs keep retiring. `inflight`=0 and no tracked write-back this cycle → RUN.
  - `flush` while in DRAIN: stays in DRAIN.
- Reset, async and at any point including mid-drain:
  - all `cnt`=0, `busy_mask`=0, `inflight`=0;
  - state RUN, `draining`=0, `err`=0.
  - `issue_ready` is 0 while `rst` is high.

## Timing
- Issue accepted at edge N: `busy_mask`/`inflight` update at N; a dependent instruction is stalled from cycle N+1.
- Write-back at edge M clears the busy bit at M, when cnt goes 1→0. Issue of a dependent reader:
  - with bypass: allowed in cycle M itself;
  - without bypass: allowed from cycle M+1.
- Flush sampled at edge F: `draining`=1 after F. Returns to RUN one cycle after the edge where `inflight` reaches 0.
- No internal latency beyond one register stage. `issue_ready` is combinational from the inputs and the registered state.

## Configuration
- `SCOREBOARD_WB_BYPASS_EN` defined: the RAW check ignores a source register r when `wb_valid` && `wb_rd`==r && `cnt[r]`==1 in the same cycle. This relies on the bank's write-before-read behaviour.
- Not defined: the RAW check uses `cnt` only, costing one extra stall cycle per dependency.

## Test plan
- Reset mid-operation: drive 3 tracked issues, assert `rst` asynchronously → `busy_mask`=0, `inflight`=0, `issue_ready`=0 while `rst` high, then 1 after release.
- RAW: issue rd=5, next cycle rs1=5 → `issue_ready`=0 until write-back of 5. Same-cycle issue then passes only with the macro defined; otherwise it passes one cycle later.
- Saturation: `DEPTH`=4, four issues to rd=1,2,3,4 → a fifth issue with `issue_wr`=1 is stalled. A fifth issue with `issue_wr`=0 and independent sources is accepted.
- Same-register issue and write-back in one cycle (rd=7, cnt[7]=1) → cnt[7] stays 1 and `inflight` is unchanged.
- rd=0 / `wb_rd`=0: issues and write-backs to register 0 leave `busy_mask`=0, never stall, never set `err`.
- Flush with `inflight`=2 → `draining`=1 and `issue_ready`=0. After two write-backs, RUN and `issue_ready`=1. A spurious write-back afterwards sets `err`=1 and it stays set.
